// File: rtl/tile_addr_gen.sv
// tile_addr_gen: sequences a nest4 tile counter and maps each counter tuple to
// base + sum(cntK*strideK), buffered in a credit-managed show-ahead FIFO.
module tile_addr_gen #(
  parameter int unsigned CW    = 16,
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] stride0,
  input  logic [AW-1:0] stride1,
  input  logic [AW-1:0] stride2,
  input  logic [AW-1:0] stride3,
  output logic          cnt_ena,
  output logic          cnt_syn_rst,
  input  logic [CW-1:0] cnt0,
  input  logic [CW-1:0] cnt1,
  input  logic [CW-1:0] cnt2,
  input  logic [CW-1:0] cnt3,
  input  logic          cnt_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          busy,
  output logic          sweep_done
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW = $clog2(DEPTH + 1);
  localparam int unsigned SW = NW + 1;

  typedef enum logic [1:0] {IDLE, INIT, ISSUE, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] base_q;
  logic [AW-1:0] stride_q [4];
  logic          last_seen, ena_q;
  logic          p0_valid, p0_last, p1_valid, p1_last;
  logic [CW-1:0] p0_cnt [4];
  logic [AW-1:0] p1_prod [4];
  logic [AW-1:0] mem [DEPTH];
  logic          mem_last [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] fifo_count, inflight, fifo_count_nxt, inflight_nxt;
  logic          done_in, fifo_wr, fifo_rd, credit_ok, drain_exit;
  logic [AW-1:0] p2_addr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // The last tuple is recognised combinationally so no extra ena follows it.
  assign done_in        = (state == ISSUE) && ena_q && cnt_done;
  assign credit_ok      = (SW'(fifo_count) + SW'(inflight)) < SW'(DEPTH);
  assign cnt_ena        = (state == ISSUE) && !last_seen && !done_in && credit_ok;
  assign fifo_wr        = p1_valid;
  assign out_valid      = (fifo_count != '0);
  assign fifo_rd        = out_valid && out_ready;
  assign out_addr       = mem[rd_ptr];
  assign out_last       = mem_last[rd_ptr];
  assign fifo_count_nxt = fifo_count + NW'(fifo_wr) - NW'(fifo_rd);
  assign inflight_nxt   = inflight + NW'(cnt_ena) - NW'(fifo_wr);
  assign p2_addr        = base_q + p1_prod[0] + p1_prod[1] + p1_prod[2] + p1_prod[3];

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    drain_exit = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT:    state_nxt = ISSUE;
      ISSUE:   if (done_in) state_nxt = DRAIN;
      DRAIN: begin
        if (inflight == '0 && fifo_count_nxt == '0) begin
          drain_exit = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control, pipeline valids and FIFO storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt_syn_rst <= 1'b0;
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
      last_seen   <= 1'b0;
      ena_q       <= 1'b0;
      p0_valid    <= 1'b0;
      p0_last     <= 1'b0;
      p1_valid    <= 1'b0;
      p1_last     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      inflight    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i]      <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      state       <= state_nxt;
      cnt_syn_rst <= (state_nxt == INIT);
      busy        <= (state_nxt != IDLE);
      sweep_done  <= drain_exit;
      if (state == INIT)  last_seen <= 1'b0;
      else if (done_in)   last_seen <= 1'b1;
      ena_q       <= cnt_ena;
      p0_valid    <= ena_q;
      p0_last     <= done_in;
      p1_valid    <= p0_valid;
      p1_last     <= p0_last;
      if (fifo_wr) begin
        mem[wr_ptr]      <= p2_addr;
        mem_last[wr_ptr] <= p1_last;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (fifo_rd) rd_ptr <= ptr_inc(rd_ptr);
      fifo_count  <= fifo_count_nxt;
      inflight    <= inflight_nxt;
    end
  end

  // Datapath registers; contents are qualified by the valids above
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      base_q      <= base_addr;
      stride_q[0] <= stride0;
      stride_q[1] <= stride1;
      stride_q[2] <= stride2;
      stride_q[3] <= stride3;
    end
    p0_cnt[0] <= cnt0;
    p0_cnt[1] <= cnt1;
    p0_cnt[2] <= cnt2;
    p0_cnt[3] <= cnt3;
    for (int k = 0; k < 4; k++) begin
      p1_prod[k] <= AW'(p0_cnt[k]) * stride_q[k];
    end
  end

  // Credits must make a push into a full FIFO without a pop impossible.
  assert property (@(posedge clk) disable iff (rst)
    !(fifo_wr && !fifo_rd && fifo_count == NW'(DEPTH)));

endmodule

// File: tb/tb_tile_addr_gen.sv
// Bench for tile_addr_gen: behavioural nest4 counter, scoreboard queue of
// expected addresses, and a negedge monitor comparing every accepted output.
`timescale 1ns/1ps
module tb_tile_addr_gen;
  localparam int unsigned CW    = 16;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic [AW-1:0] base_addr, stride0, stride1, stride2, stride3;
  logic          cnt_ena, cnt_syn_rst, cnt_done = 1'b0;
  logic [CW-1:0] cnt0 = '0, cnt1 = '0, cnt2 = '0, cnt3 = '0;
  logic          out_valid, out_last, busy, sweep_done;
  logic [AW-1:0] out_addr;

  typedef struct packed { logic [AW-1:0] addr; logic last; } exp_t;
  exp_t exp_q [$];

  int checks = 0, errors = 0, cyc = 0;
  int n [4];
  int idx = 0;
  int ena_cnt, pop_cnt, done_cnt, max_out;
  int first_syn, first_ena, first_valid, last_pop_cyc, start_cyc;

  tile_addr_gen #(.CW(CW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .stride0(stride0), .stride1(stride1), .stride2(stride2), .stride3(stride3),
    .cnt_ena(cnt_ena), .cnt_syn_rst(cnt_syn_rst),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .cnt_done(cnt_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_last(out_last), .busy(busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Nest4 counter: cnt0 fastest; tuple appears the cycle after each ena
  always @(posedge clk) begin
    if (cnt_syn_rst) begin
      idx      <= 0;
      cnt_done <= 1'b0;
    end else if (cnt_ena) begin
      cnt0     <= CW'(idx % n[0]);
      cnt1     <= CW'((idx / n[0]) % n[1]);
      cnt2     <= CW'((idx / (n[0] * n[1])) % n[2]);
      cnt3     <= CW'(idx / (n[0] * n[1] * n[2]));
      cnt_done <= (idx == n[0] * n[1] * n[2] * n[3] - 1);
      idx      <= idx + 1;
    end else begin
      cnt_done <= 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (cnt_syn_rst && first_syn < 0) first_syn = cyc;
      if (cnt_ena) begin
        ena_cnt++;
        if (first_ena < 0) first_ena = cyc;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_extra: got addr 0x%08h last %0b, nothing expected", out_addr, out_last);
        end else begin
          e = exp_q.pop_front();
          if (out_addr !== e.addr || out_last !== e.last) begin
            errors++;
            $display("FAIL scoreboard: got addr 0x%08h last %0b, expected addr 0x%08h last %0b",
                     out_addr, out_last, e.addr, e.last);
          end
        end
        pop_cnt++;
        if (out_last) last_pop_cyc = cyc;
      end
      if (ena_cnt - pop_cnt > max_out) max_out = ena_cnt - pop_cnt;
      if (sweep_done) begin
        done_cnt++;
        checks++;
        if (cyc - last_pop_cyc != 1) begin
          errors++;
          $display("FAIL sweep_done_timing: got %0d cycles after last pop, expected 1", cyc - last_pop_cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic set_cfg(input logic [AW-1:0] b, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                         input logic [AW-1:0] s2, input logic [AW-1:0] s3,
                         input int m0, input int m1, input int m2, input int m3);
    base_addr = b; stride0 = s0; stride1 = s1; stride2 = s2; stride3 = s3;
    n[0] = m0; n[1] = m1; n[2] = m2; n[3] = m3;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic l);
    exp_t e;
    e.addr = a;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic push_model();
    for (int i3 = 0; i3 < n[3]; i3++)
      for (int i2 = 0; i2 < n[2]; i2++)
        for (int i1 = 0; i1 < n[1]; i1++)
          for (int i0 = 0; i0 < n[0]; i0++)
            push_exp(base_addr + AW'(i0) * stride0 + AW'(i1) * stride1 + AW'(i2) * stride2 + AW'(i3) * stride3,
                     (i0 == n[0] - 1) && (i1 == n[1] - 1) && (i2 == n[2] - 1) && (i3 == n[3] - 1));
  endtask

  task automatic clear_stats();
    ena_cnt = 0; pop_cnt = 0; done_cnt = 0; max_out = 0;
    first_syn = -1; first_ena = -1; first_valid = -1; last_pop_cyc = -1;
  endtask

  // mode 0: ready=1, 1: random ready, 2: 20-cycle stall, 3: stray start mid-sweep
  task automatic run_sweep(input int mode);
    int total, ena_snap;
    total = n[0] * n[1] * n[2] * n[3];
    ena_snap = 0;
    clear_stats();
    @(posedge clk); #1;
    start = 1'b1; out_ready = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 2000 && done_cnt == 0; c++) begin
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          out_ready = !(c >= 15 && c < 35);
          if (c == 26) ena_snap = ena_cnt;
          if (c == 34) begin
            chk("bp_ena_stalled", 32'(ena_cnt), 32'(ena_snap));
            chk("bp_buffered_full", 32'(ena_cnt - pop_cnt), 32'(DEPTH));
          end
        end
        3: begin
          out_ready = 1'b1;
          start = (c == 6);
          if (c == 6) base_addr = 32'hDEAD_0000;
        end
        default: out_ready = 1'b1;
      endcase
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("sweep_done_seen", 32'(done_cnt), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("sweep_done_once", 32'(done_cnt), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("ena_total", 32'(ena_cnt), 32'(total));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("outstanding_le_depth", 32'(max_out <= int'(DEPTH)), 32'd1);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    set_cfg(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1, 1, 1);
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cnt_ena", 32'(cnt_ena), 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    rst = 1'b0;

    // Full sweep plus latency and throughput
    set_cfg(32'h1000, 32'd1, 32'd16, 32'd64, 32'd256, 4, 2, 2, 3);
    push_model();
    run_sweep(0);
    chk("lat_syn_rst", 32'(first_syn - start_cyc), 32'd1);
    chk("lat_cnt_ena", 32'(first_ena - start_cyc), 32'd2);
    chk("lat_out_valid", 32'(first_valid - start_cyc), 32'd6);
    chk("back_to_back", 32'(last_pop_cyc - first_valid), 32'd47);

    // Backpressure
    set_cfg(32'h1000, 32'd1, 32'd16, 32'd64, 32'd256, 4, 2, 2, 3);
    push_model();
    run_sweep(2);

    // Random ready
    set_cfg(32'h2340, 32'd3, 32'd40, 32'd0, 32'd1000, 3, 4, 2, 2);
    push_model();
    run_sweep(1);

    // Address wrap
    set_cfg(32'hFFFF_FFF0, 32'd8, 32'd0, 32'd0, 32'd0, 4, 1, 1, 1);
    push_exp(32'hFFFF_FFF0, 1'b0);
    push_exp(32'hFFFF_FFF8, 1'b0);
    push_exp(32'h0000_0000, 1'b0);
    push_exp(32'h0000_0008, 1'b1);
    run_sweep(0);

    // Stray start during ISSUE
    set_cfg(32'h1000, 32'd1, 32'd16, 32'd64, 32'd256, 4, 2, 2, 3);
    push_model();
    run_sweep(3);

    // Reset while draining, then a clean sweep
    set_cfg(32'hFFFF_FFF0, 32'd8, 32'd0, 32'd0, 32'd0, 4, 1, 1, 1);
    clear_stats();
    @(posedge clk); #1;
    start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_enas", 32'(ena_cnt), 32'd4);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_addr", out_addr, 32'd0);
    chk("mid_rst_out_last", 32'(out_last), 32'd0);
    chk("mid_rst_cnt_ena", 32'(cnt_ena), 32'd0);
    chk("mid_rst_syn_rst", 32'(cnt_syn_rst), 32'd0);
    chk("mid_rst_sweep_done", 32'(sweep_done), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_sweep_done", 32'(done_cnt), 32'd0);
    set_cfg(32'h1000, 32'd1, 32'd16, 32'd64, 32'd256, 4, 2, 2, 3);
    push_model();
    run_sweep(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
